// File: rtl/conv_out_sched.sv
// Output-side sequencer for one convolution layer: MAC pacing per pixel, then one buffer write per pixel.
// Define CONV_SCHED_PERF_CNT_EN to build the busy-cycle counter on cycle_cnt; otherwise cycle_cnt is 0.
//
// state | meaning
// IDLE  | waiting for start
// ACC   | counting M operand beats for the current pixel
// WRITE | holding the output write request until accepted
// DONE  | one-cycle end-of-layer marker
module conv_out_sched #(
  parameter int KERNEL     = 5,
  parameter int IN_GROUPS  = 1,
  parameter int OUT_ROWS   = 28,
  parameter int OUT_COLS   = 28,
  parameter int OUT_GROUPS = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              wr_stall,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [7:0]        mac_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycle_cnt
);

  localparam int M     = KERNEL * KERNEL * IN_GROUPS;
  localparam int P     = OUT_ROWS * OUT_COLS;
  localparam int PIX_W = $clog2(P + 1);
  localparam int GRP_W = $clog2(OUT_GROUPS + 1);

  localparam logic [7:0]        M_LAST = 8'(M - 1);
  localparam logic [PIX_W-1:0]  P_LAST = PIX_W'(P - 1);
  localparam logic [GRP_W-1:0]  G_LAST = GRP_W'(OUT_GROUPS - 1);
  localparam logic [ADDR_W-1:0] P_STEP = ADDR_W'(P);

  localparam longint TOTAL_WORDS = longint'(OUT_GROUPS) * longint'(P);
  localparam longint ADDR_SPAN   = longint'(1) << ADDR_W;

  if (M > 256) begin : g_chk_m
    $error("conv_out_sched: KERNEL*KERNEL*IN_GROUPS exceeds 256");
  end
  if (TOTAL_WORDS > ADDR_SPAN) begin : g_chk_addr
    $error("conv_out_sched: OUT_GROUPS*OUT_ROWS*OUT_COLS does not fit in ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mac_idx_q, mac_idx_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [GRP_W-1:0]   group_q, group_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d   = state_q;
    mac_idx_d = mac_idx_q;
    pixel_d   = pixel_q;
    group_d   = group_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACC;
          mac_idx_d = '0;
          pixel_d   = '0;
          group_d   = '0;
          base_d    = '0;
        end
      end

      S_ACC: begin
        if (in_valid) begin
          if (mac_idx_q == M_LAST) begin
            mac_idx_d = '0;
            state_d   = S_WRITE;
            wr_addr_d = base_q + ADDR_W'(pixel_q);
          end else begin
            mac_idx_d = mac_idx_q + 8'd1;
          end
        end
      end

      S_WRITE: begin
        // Address and request stay frozen until the buffer takes the word.
        if (!wr_stall) begin
          if (pixel_q < P_LAST) begin
            pixel_d = pixel_q + PIX_W'(1);
            state_d = S_ACC;
          end else if (group_q < G_LAST) begin
            pixel_d = '0;
            group_d = group_q + GRP_W'(1);
            base_d  = base_q + P_STEP;
            state_d = S_ACC;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_en_d = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mac_idx_q <= '0;
      pixel_q   <= '0;
      group_q   <= '0;
      base_q    <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_idx_q <= mac_idx_d;
      pixel_q   <= pixel_d;
      group_q   <= group_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The accumulator follows operand validity directly while in ACC.
  assign mac_en  = (state_q == S_ACC) && in_valid;
  assign mac_clr = mac_en && (mac_idx_q == 8'd0);
  assign mac_idx = mac_idx_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef CONV_SCHED_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && start) begin
      cyc_d = '0;
    end else if ((state_q == S_ACC || state_q == S_WRITE) && cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_out_sched.sv
// Directed bench for conv_out_sched: a small instance (M=4, P=4, 2 groups) and a default-parameter instance.
module tb_conv_out_sched;

`ifdef CONV_SCHED_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        rst_n_s, start_s, in_valid_s, wr_stall_s;
  logic        mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s;
  logic [7:0]  mac_idx_s;
  logic [15:0] wr_addr_s;
  logic [31:0] cycle_cnt_s;

  logic        rst_n_d, start_d, in_valid_d, wr_stall_d;
  logic        mac_en_d, mac_clr_d, wr_en_d, busy_d, done_d;
  logic [7:0]  mac_idx_d;
  logic [15:0] wr_addr_d;
  logic [31:0] cycle_cnt_d;

  conv_out_sched #(
    .KERNEL(2), .IN_GROUPS(1), .OUT_ROWS(2), .OUT_COLS(2), .OUT_GROUPS(2), .ADDR_W(16)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s), .start(start_s), .in_valid(in_valid_s), .wr_stall(wr_stall_s),
    .mac_en(mac_en_s), .mac_clr(mac_clr_s), .mac_idx(mac_idx_s), .wr_en(wr_en_s),
    .wr_addr(wr_addr_s), .busy(busy_s), .done(done_s), .cycle_cnt(cycle_cnt_s)
  );

  conv_out_sched dut_d (
    .clk(clk), .rst_n(rst_n_d), .start(start_d), .in_valid(in_valid_d), .wr_stall(wr_stall_d),
    .mac_en(mac_en_d), .mac_clr(mac_clr_d), .mac_idx(mac_idx_d), .wr_en(wr_en_d),
    .wr_addr(wr_addr_d), .busy(busy_d), .done(done_d), .cycle_cnt(cycle_cnt_d)
  );

  // Expected {mac_en, mac_clr, wr_en, busy, done, mac_idx} for cycle c of an unstalled small layer.
  // Cycle 1 is the cycle right after the start edge; 5 cycles per pixel, DONE in cycle 41.
  function automatic logic [12:0] nom_exp(int c);
    int pos;
    if (c >= 1 && c <= 40) begin
      pos = (c - 1) % 5;
      if (pos < 4) return {1'b1, (pos == 0), 1'b0, 1'b1, 1'b0, 8'(pos)};
      else         return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    end else if (c == 41) begin
      return {5'b00011, 8'd0};
    end
    return 13'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch_s();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_s = 1'b0; start_s = 1'b0; in_valid_s = 1'b0; wr_stall_s = 1'b0;
    repeat (3) tick();
    #1;
    tests++;
    if ({mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s, wr_addr_s, cycle_cnt_s} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%b clr=%b wr=%b busy=%b done=%b idx=%0d addr=%0d cnt=%0d, required all 0",
               mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s, wr_addr_s, cycle_cnt_s);
    end
    rst_n_s = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    logic [12:0] exp_v;
    launch_s();
    for (int c = 1; c <= 45; c++) begin
      in_valid_s = 1'b1; wr_stall_s = 1'b0;
      #1;
      exp_v = nom_exp(c);
      tests++;
      if ({mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s} !== exp_v) begin
        fails++;
        $display("FAIL nominal_seq c=%0d: got %h, required %h", c, {mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s}, exp_v);
      end
      if (exp_v[10]) begin
        tests++;
        if (wr_addr_s !== 16'((c - 1) / 5)) begin
          fails++;
          $display("FAIL nominal_addr c=%0d: got %0d, required %0d", c, wr_addr_s, (c - 1) / 5);
        end
      end
      tick();
    end
    tests++;
    if (cycle_cnt_s !== (PERF ? 32'd40 : 32'd0)) begin
      fails++;
      $display("FAIL nominal_cycle_cnt: got %0d, required %0d", cycle_cnt_s, PERF ? 40 : 0);
    end
  endtask

  task automatic test_bubbles();
    logic [12:0] exp_v;
    int ce;
    launch_s();
    for (int c = 1; c <= 48; c++) begin
      in_valid_s = !(c >= 3 && c <= 5); wr_stall_s = 1'b0;
      #1;
      ce = (c >= 6) ? c - 3 : c;
      if (c >= 3 && c <= 5) exp_v = {5'b00010, 8'd2};
      else                  exp_v = nom_exp(ce);
      tests++;
      if ({mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s} !== exp_v) begin
        fails++;
        $display("FAIL bubble_seq c=%0d: got %h, required %h", c, {mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s}, exp_v);
      end
      if (exp_v[10]) begin
        tests++;
        if (wr_addr_s !== 16'((ce - 1) / 5)) begin
          fails++;
          $display("FAIL bubble_addr c=%0d: got %0d, required %0d", c, wr_addr_s, (ce - 1) / 5);
        end
      end
      tick();
    end
    in_valid_s = 1'b1;
    tests++;
    if (cycle_cnt_s !== (PERF ? 32'd43 : 32'd0)) begin
      fails++;
      $display("FAIL bubble_cycle_cnt: got %0d, required %0d", cycle_cnt_s, PERF ? 43 : 0);
    end
  endtask

  task automatic test_write_stall();
    logic [12:0] exp_v;
    int ce;
    launch_s();
    for (int c = 1; c <= 50; c++) begin
      in_valid_s = 1'b1; wr_stall_s = (c >= 20 && c <= 23);
      #1;
      ce = (c >= 25) ? c - 4 : c;
      if (c >= 20 && c <= 24) exp_v = {5'b00110, 8'd0};
      else                    exp_v = nom_exp(ce);
      tests++;
      if ({mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s} !== exp_v) begin
        fails++;
        $display("FAIL stall_seq c=%0d: got %h, required %h", c, {mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s}, exp_v);
      end
      if (exp_v[10]) begin
        tests++;
        if (wr_addr_s !== ((c >= 20 && c <= 24) ? 16'd3 : 16'((ce - 1) / 5))) begin
          fails++;
          $display("FAIL stall_addr c=%0d: got %0d, required %0d", c, wr_addr_s, (c >= 20 && c <= 24) ? 3 : (ce - 1) / 5);
        end
      end
      tick();
    end
    wr_stall_s = 1'b0;
    tests++;
    if (cycle_cnt_s !== (PERF ? 32'd44 : 32'd0)) begin
      fails++;
      $display("FAIL stall_cycle_cnt: got %0d, required %0d", cycle_cnt_s, PERF ? 44 : 0);
    end
  endtask

  task automatic test_abort_restart();
    logic [12:0] exp_v;
    launch_s();
    for (int c = 1; c <= 30; c++) begin
      in_valid_s = 1'b1; start_s = (c == 2); rst_n_s = (c != 30);
      #1;
      exp_v = nom_exp(c);
      tests++;
      if ({mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s} !== exp_v) begin
        fails++;
        $display("FAIL ignore_start_seq c=%0d: got %h, required %h", c, {mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s}, exp_v);
      end
      tick();
    end
    start_s = 1'b0; rst_n_s = 1'b1;
    for (int c = 31; c <= 50; c++) begin
      #1;
      tests++;
      if ({mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s} !== 13'd0) begin
        fails++;
        $display("FAIL abort_quiet c=%0d: got %h, required 0", c, {mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s});
      end
      tick();
    end
    launch_s();
    for (int c = 1; c <= 42; c++) begin
      #1;
      exp_v = nom_exp(c);
      tests++;
      if ({mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s} !== exp_v) begin
        fails++;
        $display("FAIL restart_seq c=%0d: got %h, required %h", c, {mac_en_s, mac_clr_s, wr_en_s, busy_s, done_s, mac_idx_s}, exp_v);
      end
      if (c == 5) begin
        tests++;
        if (wr_addr_s !== 16'd0) begin
          fails++;
          $display("FAIL restart_addr: got %0d, required 0", wr_addr_s);
        end
      end
      tick();
    end
  endtask

  task automatic test_default_params();
    int nwr = 0, ndone = 0, done_at = 0, nbusy = 0, first_wr_at = 0;
    logic [15:0] last_addr = 16'hFFFF;
    rst_n_d = 1'b1;
    tick();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int c = 1; c <= 41000; c++) begin
      #1;
      if (wr_en_d) begin
        nwr++;
        last_addr = wr_addr_d;
        if (first_wr_at == 0) first_wr_at = c;
      end
      if (busy_d && !done_d) nbusy++;
      if (done_d) begin
        ndone++;
        done_at = c;
      end
      tick();
    end
    tests++;
    if (first_wr_at !== 26) begin
      fails++;
      $display("FAIL default_first_write: got cycle %0d, required 26", first_wr_at);
    end
    tests++;
    if (nwr !== 1568) begin
      fails++;
      $display("FAIL default_write_count: got %0d, required 1568", nwr);
    end
    tests++;
    if (last_addr !== 16'd1567) begin
      fails++;
      $display("FAIL default_last_addr: got %0d, required 1567", last_addr);
    end
    tests++;
    if (ndone !== 1 || done_at !== 40769) begin
      fails++;
      $display("FAIL default_done: got %0d pulses at cycle %0d, required 1 at 40769", ndone, done_at);
    end
    tests++;
    if (nbusy !== 40768) begin
      fails++;
      $display("FAIL default_busy_cycles: got %0d, required 40768", nbusy);
    end
    tests++;
    if (cycle_cnt_d !== (PERF ? 32'd40768 : 32'd0)) begin
      fails++;
      $display("FAIL default_cycle_cnt: got %0d, required %0d", cycle_cnt_d, PERF ? 40768 : 0);
    end
  endtask

  initial begin
    rst_n_d = 1'b0; start_d = 1'b0; in_valid_d = 1'b1; wr_stall_d = 1'b0;
    test_reset();
    test_nominal();
    test_bubbles();
    test_write_stall();
    test_abort_restart();
    test_default_params();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
